// File: rtl/seq_div_32_if.sv
// seq_div_32_if: request/result bundle for the sequential divider.
//   START        request, sampled when the divider is idle or finishing
//   OP1 / OP2    dividend / divisor, sampled with START
//   QUOT / REM   registered quotient / remainder of the last result
//   BUSY         division in progress
//   DONE         one-cycle pulse marking a new result
//   DIV_BY_ZERO  last result came from a zero divisor
interface seq_div_32_if;
  logic        START;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [31:0] QUOT;
  logic [31:0] REM;
  logic        BUSY;
  logic        DONE;
  logic        DIV_BY_ZERO;

  modport master (output START, OP1, OP2,
                  input  QUOT, REM, BUSY, DONE, DIV_BY_ZERO);
  modport slave  (input  START, OP1, OP2,
                  output QUOT, REM, BUSY, DONE, DIV_BY_ZERO);
endinterface

// File: rtl/seq_div_32.sv
// seq_div_32: 32-bit unsigned restoring divider, one quotient bit per clock.
//   CLK   rising-edge clock
//   RST   asynchronous active-low reset
//   bus   seq_div_32_if.slave (START/OP1/OP2 in, QUOT/REM/BUSY/DONE/DIV_BY_ZERO out)
// A nonzero divisor takes 32 cycles from the accept edge to DONE; a zero
// divisor finishes on the accept edge with QUOT=all-ones and REM=dividend.
module seq_div_32 (
  input logic         CLK,
  input logic         RST,
  seq_div_32_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state, stateNxt;
  logic [31:0] q, r, d;
  logic [5:0]  cnt;
  logic [31:0] quotReg, remReg;
  logic        dbzReg;

  logic [32:0] s;
  logic [31:0] t;
  logic        co;
  logic        accept;
  logic [31:0] qNext, rNext;
  logic        startOk;
  logic        lastIter;

  // Shift the next dividend bit into the partial remainder.
  assign s = {r, q[31]};

  // Ripple add/sub in subtract mode: S + ~D + 1, carry-in of 1.
  always_comb begin
    logic c;
    t = '0;
    c = 1'b1;
    for (int i = 0; i < 32; i++) begin
      t[i] = s[i] ^ ~d[i] ^ c;
      c    = (s[i] & ~d[i]) | (c & (s[i] ^ ~d[i]));
    end
    co = c;
  end

  // S[32] set means S >= 2^32 > D, so the subtract fits even though the
  // 32-bit adder shows a borrow.
  assign accept   = s[32] | co;
  assign rNext    = accept ? t : s[31:0];
  assign qNext    = {q[30:0], accept};
  assign startOk  = bus.START && (state != RUN);
  assign lastIter = (state == RUN) && (cnt == 6'd31);

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE, FIN: begin
        if (bus.START)        stateNxt = (bus.OP2 == 32'd0) ? FIN : RUN;
        else if (state == FIN) stateNxt = IDLE;
      end
      RUN:     if (cnt == 6'd31) stateNxt = FIN;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      q       <= '0;
      r       <= '0;
      d       <= '0;
      cnt     <= '0;
      quotReg <= '0;
      remReg  <= '0;
      dbzReg  <= 1'b0;
    end else begin
      state <= stateNxt;
      if (startOk) begin
        if (bus.OP2 != 32'd0) begin
          q   <= bus.OP1;
          r   <= '0;
          d   <= bus.OP2;
          cnt <= '0;
        end else begin
          quotReg <= '1;
          remReg  <= bus.OP1;
          dbzReg  <= 1'b1;
        end
      end
      if (state == RUN) begin
        q   <= qNext;
        r   <= rNext;
        cnt <= cnt + 6'd1;
      end
      // Results only move on entry to FIN; they hold through IDLE and the next RUN.
      if (lastIter) begin
        quotReg <= qNext;
        remReg  <= rNext;
        dbzReg  <= 1'b0;
      end
    end
  end

  assign bus.QUOT        = quotReg;
  assign bus.REM         = remReg;
  assign bus.DIV_BY_ZERO = dbzReg;
  assign bus.BUSY        = (state == RUN);
  assign bus.DONE        = (state == FIN);

endmodule

// File: tb/tb_seq_div_32.sv
module tb_seq_div_32;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  seq_div_32_if bus ();

  seq_div_32 dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int   total = 0;
  int   bad = 0;
  int   cycNo = 0;
  int   acceptCyc = 0;
  int   doneCnt = 0;
  exp_t sb[$];

  always @(posedge CLK) cycNo++;
  // DONE is counted per clock it is seen high, so a stretched pulse shows up.
  always @(posedge CLK) if (bus.DONE === 1'b1) doneCnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) e = '{q: 32'hFFFFFFFF, r: a, z: 1'b1};
    else            e = '{q: a / b, r: a % b, z: 1'b0};
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.START = 1'b1;
    bus.OP1   = a;
    bus.OP2   = b;
    if (push) sb.push_back(model(a, b));
    @(posedge CLK);
    #1 acceptCyc = cycNo;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyN);
    busyN = 0;
    lat   = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.DONE === 1'b1) begin
        lat = cycNo - acceptCyc;
        break;
      end
      if (bus.BUSY === 1'b1) busyN++;
      @(negedge CLK);
    end
  endtask

  task automatic popExp(output exp_t e);
    if (sb.size() == 0) e = 'x;
    else                e = sb.pop_front();
  endtask

  task automatic test_reset;
    bus.START = 1'b0; bus.OP1 = '0; bus.OP2 = '0;
    RST = 1'b0;
    #12;
    total++;
    if ({bus.QUOT, bus.REM, bus.BUSY, bus.DONE, bus.DIV_BY_ZERO} !== 67'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {bus.QUOT, bus.REM, bus.BUSY, bus.DONE, bus.DIV_BY_ZERO});
    end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic;
    int lat, busyN; exp_t e;
    issue(32'd100, 32'd7, 1);
    waitDone(lat, busyN);
    popExp(e);
    total++;
    if (lat !== 32) begin bad++; $display("FAIL basic_latency got=%0d want=32", lat); end
    total++;
    if (busyN !== 32) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=32", busyN); end
    total++;
    if (bus.QUOT !== e.q || bus.REM !== e.r || bus.DIV_BY_ZERO !== e.z || bus.BUSY !== 1'b0) begin
      bad++;
      $display("FAIL basic_result got=%h/%h z=%b busy=%b want=%h/%h z=%b busy=0",
               bus.QUOT, bus.REM, bus.DIV_BY_ZERO, bus.BUSY, e.q, e.r, e.z);
    end
    @(negedge CLK);
    total++;
    if (bus.DONE !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", bus.DONE); end
  endtask

  task automatic test_operands;
    logic [31:0] as [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    logic [31:0] bs [4] = '{32'h80000000, 32'd9, 32'hFFFFFFFF, 32'd3};
    int lat, busyN; exp_t e;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      if (i < 4) begin a = as[i]; b = bs[i]; end
      else begin
        a = $urandom;
        b = $urandom >> $urandom_range(0, 31);
        if (b == 32'd0) b = 32'd1;
      end
      issue(a, b, 1);
      waitDone(lat, busyN);
      popExp(e);
      total++;
      if (lat !== 32 || bus.QUOT !== e.q || bus.REM !== e.r || bus.DIV_BY_ZERO !== e.z) begin
        bad++;
        $display("FAIL operands_%0d %h/%h got=%h/%h z=%b lat=%0d want=%h/%h z=%b lat=32",
                 i, a, b, bus.QUOT, bus.REM, bus.DIV_BY_ZERO, lat, e.q, e.r, e.z);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_div_zero;
    int lat, busyN; exp_t e;
    issue(32'd5, 32'd0, 1);
    waitDone(lat, busyN);
    popExp(e);
    total++;
    if (lat !== 0 || busyN !== 0) begin
      bad++;
      $display("FAIL dbz_timing got lat=%0d busy=%0d want lat=0 busy=0", lat, busyN);
    end
    total++;
    if (bus.QUOT !== e.q || bus.REM !== e.r || bus.DIV_BY_ZERO !== e.z) begin
      bad++;
      $display("FAIL dbz_result got=%h/%h z=%b want=%h/%h z=%b",
               bus.QUOT, bus.REM, bus.DIV_BY_ZERO, e.q, e.r, e.z);
    end
    @(negedge CLK);
    issue(32'd10, 32'd3, 1);
    total++;
    if (bus.DIV_BY_ZERO !== 1'b1) begin
      bad++; $display("FAIL dbz_flag_hold got=%b want=1", bus.DIV_BY_ZERO);
    end
    waitDone(lat, busyN);
    popExp(e);
    total++;
    if (lat !== 32 || bus.QUOT !== e.q || bus.REM !== e.r || bus.DIV_BY_ZERO !== e.z) begin
      bad++;
      $display("FAIL dbz_clear got=%h/%h z=%b lat=%0d want=%h/%h z=%b lat=32",
               bus.QUOT, bus.REM, bus.DIV_BY_ZERO, lat, e.q, e.r, e.z);
    end
    @(negedge CLK);
  endtask

  task automatic test_start_ignored;
    int lat, busyN, d0; exp_t e;
    d0 = doneCnt;
    issue(32'd1000, 32'd10, 1);
    repeat (10) @(negedge CLK);
    bus.START = 1'b1; bus.OP1 = 32'd9; bus.OP2 = 32'd3;
    @(negedge CLK);
    bus.START = 1'b0;
    waitDone(lat, busyN);
    popExp(e);
    total++;
    if (lat !== 32 || bus.QUOT !== e.q || bus.REM !== e.r) begin
      bad++;
      $display("FAIL ignored_result got=%h/%h lat=%0d want=%h/%h lat=32",
               bus.QUOT, bus.REM, lat, e.q, e.r);
    end
    repeat (3) @(negedge CLK);
    total++;
    if (doneCnt - d0 !== 1) begin
      bad++; $display("FAIL ignored_done_count got=%0d want=1", doneCnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    int lat, busyN; exp_t e1, e2;
    issue(32'd1000, 32'd10, 1);
    while (cycNo - acceptCyc < 31) @(negedge CLK);
    // Held high across the final iteration edge and the FIN edge.
    bus.START = 1'b1; bus.OP1 = 32'hFFFFFFFF; bus.OP2 = 32'd1;
    sb.push_back(model(32'hFFFFFFFF, 32'd1));
    @(negedge CLK);
    popExp(e1);
    total++;
    if (bus.DONE !== 1'b1 || bus.QUOT !== e1.q || bus.REM !== e1.r) begin
      bad++;
      $display("FAIL b2b_first got done=%b %h/%h want done=1 %h/%h",
               bus.DONE, bus.QUOT, bus.REM, e1.q, e1.r);
    end
    @(posedge CLK);
    #1 acceptCyc = cycNo;
    @(negedge CLK);
    bus.START = 1'b0;
    total++;
    if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
      bad++; $display("FAIL b2b_restart got busy=%b done=%b want busy=1 done=0", bus.BUSY, bus.DONE);
    end
    repeat (20) @(negedge CLK);
    total++;
    if (bus.QUOT !== e1.q || bus.REM !== e1.r) begin
      bad++; $display("FAIL b2b_hold got=%h/%h want=%h/%h", bus.QUOT, bus.REM, e1.q, e1.r);
    end
    waitDone(lat, busyN);
    popExp(e2);
    total++;
    if (lat !== 32 || bus.QUOT !== e2.q || bus.REM !== e2.r) begin
      bad++;
      $display("FAIL b2b_second got=%h/%h lat=%0d want=%h/%h lat=32",
               bus.QUOT, bus.REM, lat, e2.q, e2.r);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_run;
    int lat, busyN, d0; exp_t e;
    issue(32'd100, 32'd7, 0);
    while (cycNo - acceptCyc < 16) @(negedge CLK);
    d0 = doneCnt;
    #2 RST = 1'b0;
    #1;
    total++;
    if ({bus.QUOT, bus.REM, bus.BUSY, bus.DONE, bus.DIV_BY_ZERO} !== 67'd0) begin
      bad++;
      $display("FAIL midrun_async_clear got=%h want=0",
               {bus.QUOT, bus.REM, bus.BUSY, bus.DONE, bus.DIV_BY_ZERO});
    end
    repeat (20) @(negedge CLK);
    total++;
    if (doneCnt !== d0 || bus.DONE !== 1'b0) begin
      bad++; $display("FAIL midrun_no_done got=%0d want=0", doneCnt - d0);
    end
    RST = 1'b1;
    @(negedge CLK);
    issue(32'd100, 32'd7, 1);
    waitDone(lat, busyN);
    popExp(e);
    total++;
    if (lat !== 32 || bus.QUOT !== e.q || bus.REM !== e.r || bus.DIV_BY_ZERO !== e.z) begin
      bad++;
      $display("FAIL midrun_recover got=%h/%h lat=%0d want=%h/%h lat=32",
               bus.QUOT, bus.REM, lat, e.q, e.r);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_operands;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
